// File: rtl/noc_arb_pkg.sv
// Shared definitions for the router output-port arbiters: port codes, lock states, credit width.
package noc_arb_pkg;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_S = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_E = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width able to hold every value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_onehot_picker.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ... (mod N); one-hot or zero.
// Purely combinational, zero latency; no backpressure of its own.
module rr_onehot_picker #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr is written last.
    always_comb begin
        gnt_o = '0;
        sum   = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            idx = sum[PW-1:0];
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_rr_output_arbiter.sv
// Round-robin output-port arbiter with wormhole locking and downstream credit tracking.
// Zero-cycle grant; no grant while credits are exhausted, state advances on the following edge.
module noc_rr_output_arbiter
    import noc_arb_pkg::*;
#(
    parameter int                NUM_IN       = 4,
    parameter int                ADDR_W       = 3,
    parameter logic [ADDR_W-1:0] PORT_ID      = ADDR_W'(PORT_W),
    parameter int                CREDIT_DEPTH = 4,
    localparam int               IDX_W        = $clog2(NUM_IN),
    localparam int               CRED_W       = credit_width(CREDIT_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        req_valid_i,
    input  logic [NUM_IN*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_IN-1:0]        req_tail_i,
    input  logic                     credit_return_i,
    output logic [NUM_IN-1:0]        grant_o,
    output logic                     grant_valid_o,
    output logic [IDX_W-1:0]         grant_idx_o,
    output logic                     locked_o,
    output logic [CRED_W-1:0]        credits_o,
    output logic                     credit_err_o
);

    arb_state_t        state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;
    logic [CRED_W-1:0] credits_q;
    logic [CRED_W-1:0] credits_d;
    logic              err_q;
    logic              err_d;

    logic [NUM_IN-1:0] elig;
    logic [NUM_IN-1:0] pick_req;
    logic [NUM_IN-1:0] pick_gnt;
    logic              win_tail;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            elig[i] = req_valid_i[i] && (req_addr_i[i*ADDR_W +: ADDR_W] == PORT_ID);
        end
    end

    // While a packet owns the port, everyone but the owner is masked out.
    assign pick_req = (state_q == ARB_LOCKED) ? (elig & (NUM_IN'(1) << owner_q)) : elig;

    rr_onehot_picker #(.N(NUM_IN)) u_picker (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    assign grant_o       = ((credits_q != '0) && !reset) ? pick_gnt : '0;
    assign grant_valid_o = |grant_o;
    assign win_tail      = |(grant_o & req_tail_i);

    always_comb begin
        grant_idx_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_o[i]) begin
                grant_idx_o = IDX_W'(i);
            end
        end
    end

    assign ptr_d = (grant_idx_o == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx_o + IDX_W'(1);

    // A return arriving with the counter already full is a protocol error; the count saturates.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({grant_valid_o, credit_return_i})
            2'b10: credits_d = credits_q - CRED_W'(1);
            2'b01: begin
                if (credits_q == CRED_W'(CREDIT_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CRED_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            credits_q <= CRED_W'(CREDIT_DEPTH);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
            if (grant_valid_o) begin
                if (win_tail) begin
                    state_q <= ARB_IDLE;
                    ptr_q   <= ptr_d;
                end else begin
                    state_q <= ARB_LOCKED;
                    owner_q <= grant_idx_o;
                end
            end
        end
    end

    assign locked_o     = (state_q == ARB_LOCKED);
    assign credits_o    = credits_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_noc_rr_output_arbiter.sv
// Directed bench for noc_rr_output_arbiter at default parameters (4 inputs, PORT_ID 2, depth 4).
module tb_noc_rr_output_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid_i;
    logic [11:0] req_addr_i;
    logic [3:0]  req_tail_i;
    logic        credit_return_i;
    logic [3:0]  grant_o;
    logic        grant_valid_o;
    logic [1:0]  grant_idx_o;
    logic        locked_o;
    logic [2:0]  credits_o;
    logic        credit_err_o;

    int checks = 0;
    int errors = 0;

    noc_rr_output_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_tail_i      (req_tail_i),
        .credit_return_i (credit_return_i),
        .grant_o         (grant_o),
        .grant_valid_o   (grant_valid_o),
        .grant_idx_o     (grant_idx_o),
        .locked_o        (locked_o),
        .credits_o       (credits_o),
        .credit_err_o    (credit_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [3:0] ok;
        logic [3:0] tail;
        logic       cret;
        logic [3:0] gnt;
        logic       lck;
        logic [2:0] cred;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] ok, logic [3:0] tail, logic cret,
                                logic [3:0] gnt, logic lck, logic [2:0] cred, logic err);
        vec_t r;
        r.v = v; r.ok = ok; r.tail = tail; r.cret = cret;
        r.gnt = gnt; r.lck = lck; r.cred = cred; r.err = err;
        return r;
    endfunction

    task automatic drive(logic [3:0] v, logic [3:0] ok, logic [3:0] tail, logic cret);
        req_valid_i     = v;
        req_tail_i      = tail;
        credit_return_i = cret;
        for (int i = 0; i < 4; i++) begin
            req_addr_i[i*3 +: 3] = ok[i] ? 3'd2 : 3'd5;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [3:0] gnt, logic lck, logic [2:0] cred, logic err);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) idx = 2'(i);
        end
        chk({tag, " grant_o"}, 32'(grant_o), 32'(gnt));
        chk({tag, " grant_valid_o"}, 32'(grant_valid_o), 32'(|gnt));
        chk({tag, " grant_idx_o"}, 32'(grant_idx_o), 32'(idx));
        chk({tag, " locked_o"}, 32'(locked_o), 32'(lck));
        chk({tag, " credits_o"}, 32'(credits_o), 32'(cred));
        chk({tag, " credit_err_o"}, 32'(credit_err_o), 32'(err));
    endtask

    initial begin
        // Rotation over inputs 0,1,3 with returns keeping credits full.
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(4'b1011, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 3'd4, 1'b0));
            tbl.push_back(mk(4'b1011, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 3'd4, 1'b0));
            if (r == 0) tbl.push_back(mk(4'b1011, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0, 3'd4, 1'b0));
        end
        // Wormhole on input 2 with input 0 competing; owner idle one cycle mid-packet.
        tbl.push_back(mk(4'b0101, 4'b1111, 4'b0001, 1'b0, 4'b0100, 1'b0, 3'd4, 1'b0));
        tbl.push_back(mk(4'b0101, 4'b1111, 4'b0001, 1'b0, 4'b0100, 1'b1, 3'd3, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(4'b0101, 4'b1111, 4'b0101, 1'b0, 4'b0100, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b0, 3'd1, 1'b0));
        // Address filter: only input 1 targets this port.
        tbl.push_back(mk(4'b1111, 4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b0, 3'd1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b0, 3'd1, 1'b0));
        // Refill to 4, drain to 0, one return buys exactly one grant.
        for (int c = 1; c <= 3; c++)
            tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'(c), 1'b0));
        for (int c = 4; c >= 1; c--)
            tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b0, 3'(c), 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0));
        // Grant+return at 2 holds; return at full sets sticky error.
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b0, 3'd2, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd2, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd4, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b1));
        tbl.push_back(mk(4'b0001, 4'b1111, 4'b0001, 1'b0, 4'b0001, 1'b0, 3'd4, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 3'd3, 1'b1));

        // Reset with requests present: grant must be gated.
        reset = 1'b1;
        drive(4'b1111, 4'b1111, 4'b1111, 1'b0);
        repeat (2) @(posedge clk);
        #3 chk_all("reset", 4'b0000, 1'b0, 3'd4, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b0000, 4'b1111, 4'b1111, 1'b0);

        for (int n = 0; n < tbl.size(); n++) begin
            @(posedge clk);
            #1 drive(tbl[n].v, tbl[n].ok, tbl[n].tail, tbl[n].cret);
            #3 chk_all($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].lck, tbl[n].cred, tbl[n].err);
        end

        // Lock onto input 3, then reset mid-packet.
        @(posedge clk);
        #1 drive(4'b1000, 4'b1111, 4'b0000, 1'b0);
        #3 chk_all("head3", 4'b1000, 1'b0, 3'd3, 1'b1);
        @(posedge clk);
        #1 drive(4'b1001, 4'b1111, 4'b0000, 1'b0);
        #2 chk_all("body3", 4'b1000, 1'b1, 3'd2, 1'b1);
        reset = 1'b1;
        #1 chk_all("async_rst", 4'b0000, 1'b0, 3'd4, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b1001, 4'b1111, 4'b1111, 1'b0);
        #3 chk_all("post_rst", 4'b0001, 1'b0, 3'd4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
